// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: shared op codes, FSM states and entry widths for the arithmetic command sequencer
package arith_seq_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_CAPTURE} state_t;
  localparam logic [15:0] DBZ_RESULT = 16'hFFFF;
  localparam int RES_W = 27;
  localparam int CMD_W = 18;
endpackage

// File: rtl/arith_sync_fifo.sv
// arith_sync_fifo: show-ahead sync FIFO; ports clk, rst_n, w_en/w_data push, r_en pop, r_data head, full, empty
// A push while full is accepted only together with a pop. When empty, r_data holds the last popped entry.
module arith_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         w_en,
  input  logic [W-1:0] w_data,
  input  logic         r_en,
  output logic [W-1:0] r_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] last;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd = r_en && !empty;
  assign wr = w_en && (!full || rd);
  assign r_data = empty ? last : mem[rptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      last <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) begin
        rptr <= rptr + 1'b1;
        last <= mem[rptr];
      end
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= w_data;
endmodule

// File: rtl/arith_cmd_sequencer.sv
// arith_cmd_sequencer: queues arithmetic commands, drives them to a combinational unit, queues results
// Ports: cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_sel command stream; op_a/op_b/op_sel to unit, op_c/op_rem back;
// res_valid/res_ready/res_c/res_rem/res_sel/res_dbz result stream; busy.
// Optional ARITH_SEQ_DBZ_CNT_EN adds dbz_count (saturating divide-by-zero count) and dbz_clr.
module arith_cmd_sequencer
  import arith_seq_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [1:0]  cmd_sel,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  output logic [1:0]  op_sel,
  input  logic [15:0] op_c,
  input  logic [7:0]  op_rem,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_c,
  output logic [7:0]  res_rem,
  output logic [1:0]  res_sel,
  output logic        res_dbz,
  output logic        busy
`ifdef ARITH_SEQ_DBZ_CNT_EN
  ,
  output logic [7:0]  dbz_count,
  input  logic        dbz_clr
`endif
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_t st, nxt;
  logic [CMD_W-1:0] cmd_head;
  logic [RES_W-1:0] res_entry, res_head;
  logic [CW-1:0] cnt;
  logic cmd_full, cmd_empty, res_full, res_empty, pop, push, res_pop, dbz;
  assign cmd_ready = !cmd_full;
  assign res_valid = !res_empty;
  assign res_pop = res_valid && res_ready;
  assign busy = st != ST_IDLE || !cmd_empty;
  assign dbz = op_sel == OP_DIV && op_b == 8'd0;
  assign res_entry = {dbz ? DBZ_RESULT : op_c, dbz ? op_a : (op_sel == OP_DIV ? op_rem : 8'd0), op_sel, dbz};
  assign {res_c, res_rem, res_sel, res_dbz} = res_head;
  arith_sync_fifo #(.W(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd (
    .clk(clk), .rst_n(rst_n), .w_en(cmd_valid && cmd_ready), .w_data({cmd_a, cmd_b, cmd_sel}),
    .r_en(pop), .r_data(cmd_head), .full(cmd_full), .empty(cmd_empty)
  );
  // Result FIFO accepts a push when full if the consumer pops in the same cycle.
  arith_sync_fifo #(.W(RES_W), .DEPTH(RES_DEPTH)) u_res (
    .clk(clk), .rst_n(rst_n), .w_en(push), .w_data(res_entry),
    .r_en(res_pop), .r_data(res_head), .full(res_full), .empty(res_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= ST_IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    pop = 1'b0;
    push = 1'b0;
    case (st)
      ST_IDLE: begin
        pop = !cmd_empty;
        nxt = cmd_empty ? ST_IDLE : ST_DRIVE;
      end
      ST_DRIVE: nxt = cnt == '0 ? ST_CAPTURE : ST_DRIVE;
      ST_CAPTURE: begin
        push = !res_full || res_pop;
        nxt = push ? ST_IDLE : ST_CAPTURE;
      end
      default: nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      op_sel <= '0;
      cnt <= '0;
    end else if (pop) begin
      {op_a, op_b, op_sel} <= cmd_head;
      cnt <= CW'(SETTLE_CYCLES - 1);
    end else if (st == ST_DRIVE && cnt != '0) cnt <= cnt - 1'b1;
`ifdef ARITH_SEQ_DBZ_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dbz_count <= '0;
    else if (dbz_clr) dbz_count <= '0;
    else if (push && dbz && dbz_count != 8'hFF) dbz_count <= dbz_count + 1'b1;
`endif
endmodule
